// File: rtl/switch_reader.sv
// Bus-readable slide switches and debounced push buttons with one-cycle read latency.
// Optional build macro BTN_EVENT_EN adds a sticky button-press event register with read-and-clear.
module switch_reader #(
  parameter logic [4:0] DEVICE_ID       = 5'b00001,
  parameter int         DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  device,
  input  logic [5:0]  command,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  output logic [31:0] data_out,
  output logic        data_valid
);

  localparam logic [5:0]  CMD_READ_SW      = 6'b000010;
  localparam logic [5:0]  CMD_READ_BTN     = 6'b000011;
  localparam logic [5:0]  CMD_READ_CLR_EVT = 6'b000100;
  localparam logic [15:0] CNT_MAX          = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] sw_meta, sw_sync;
  logic [4:0]  btn_meta, btn_sync;
  logic [4:0]  btn_db, db_next;
  logic [15:0] cnt      [5];
  logic [15:0] cnt_next [5];
  logic        selected;

  assign selected = (device == DEVICE_ID);

  // Two-flop synchronizers for the asynchronous board inputs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    db_next = btn_db;
    for (int i = 0; i < 5; i++) begin
      cnt_next[i] = '0;
      if (btn_sync[i] != btn_db[i]) begin
        if (cnt[i] == CNT_MAX) db_next[i] = btn_sync[i];
        else                   cnt_next[i] = cnt[i] + 16'd1;
      end
    end
  end

  // NOTE: the small counter array is reset explicitly; it is flop-based state, not a RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      btn_db <= db_next;
      for (int i = 0; i < 5; i++) cnt[i] <= cnt_next[i];
    end
  end

`ifdef BTN_EVENT_EN
  logic [4:0] events;
  logic       evt_clr;

  assign evt_clr = selected && (command == CMD_READ_CLR_EVT);

  // A rise landing on the clearing cycle survives the clear but is not in the returned data.
  always_ff @(posedge clk) begin
    if (reset) events <= '0;
    else       events <= (evt_clr ? 5'd0 : events) | (db_next & ~btn_db);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (selected) begin
      case (command)
        CMD_READ_SW: begin
          data_out   <= {16'd0, sw_sync};
          data_valid <= 1'b1;
        end
        CMD_READ_BTN: begin
          data_out   <= {27'd0, btn_db};
          data_valid <= 1'b1;
        end
`ifdef BTN_EVENT_EN
        CMD_READ_CLR_EVT: begin
          data_out   <= {27'd0, events};
          data_valid <= 1'b1;
        end
`endif
        default: data_valid <= 1'b0;
      endcase
    end else begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_reader.sv
// Self-checking bench for switch_reader (DEBOUNCE_CYCLES = 4): directed scenarios then random traffic
// compared every cycle against a behavioural model; honours BTN_EVENT_EN when defined.
module tb_switch_reader;

  localparam int         N  = 4;
  localparam logic [4:0] ID = 5'b00001;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  device;
  logic [5:0]  command;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic [31:0] data_out;
  logic        data_valid;

  int tests = 0;
  int fails = 0;

  switch_reader #(.DEVICE_ID(ID), .DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .reset(reset), .device(device), .command(command),
    .sw(sw), .btn(btn), .data_out(data_out), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  // Reference model: inputs reach the logic two edges after sampling; a button's accepted value
  // flips once it has disagreed for N consecutive sampled cycles.
  logic [15:0] sw_hist  [2];
  logic [4:0]  btn_hist [2];
  logic [4:0]  m_db = '0;
  int          m_run [5];
  logic [4:0]  m_evt = '0;
  logic [31:0] m_dout = '0;
  logic        m_dv = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [4:0] rise;
    rise = '0;
    if (reset) begin
      sw_hist[0] = '0; sw_hist[1] = '0; btn_hist[0] = '0; btn_hist[1] = '0;
      m_db = '0; m_evt = '0; m_dout = '0; m_dv = 1'b0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
    end else begin
      m_dv = 1'b0;
      if (device == ID) begin
        if (command == 6'd2) begin m_dout = 32'(sw_hist[1]); m_dv = 1'b1; end
        if (command == 6'd3) begin m_dout = 32'(m_db); m_dv = 1'b1; end
`ifdef BTN_EVENT_EN
        if (command == 6'd4) begin m_dout = 32'(m_evt); m_dv = 1'b1; end
`endif
      end
      for (int i = 0; i < 5; i++) begin
        if (btn_hist[1][i] != m_db[i]) m_run[i]++;
        else                           m_run[i] = 0;
        if (m_run[i] == N) begin
          m_db[i] = btn_hist[1][i];
          rise[i] = btn_hist[1][i];
          m_run[i] = 0;
        end
      end
`ifdef BTN_EVENT_EN
      if (device == ID && command == 6'd4) m_evt = '0;
`endif
      m_evt = m_evt | rise;
      sw_hist[1] = sw_hist[0];   sw_hist[0] = sw;
      btn_hist[1] = btn_hist[0]; btn_hist[0] = btn;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model data_out", data_out, m_dout);
    check("model data_valid", 32'(data_valid), 32'(m_dv));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    // Command present during reset must be ignored.
    reset = 1'b1; device = ID; command = 6'd2; sw = 16'hFFFF; btn = '0;
    ticks(2);
    check("reset data_out", data_out, 32'h0);
    check("reset data_valid", 32'(data_valid), 32'h0);
    reset = 1'b0; command = 6'd0; sw = 16'hA5C3;
    ticks(3);
    command = 6'd2;
    tick();
    check("read_sw data", data_out, 32'h0000A5C3);
    check("read_sw valid", 32'(data_valid), 32'h1);
    command = 6'd0;
    tick();
    check("read_sw pulse end", 32'(data_valid), 32'h0);
    check("read_sw hold", data_out, 32'h0000A5C3);

    // Other device, then a non-read command to this device.
    sw = 16'h1234; device = 5'b00010; command = 6'd2;
    ticks(3);
    check("other dev valid", 32'(data_valid), 32'h0);
    check("other dev hold", data_out, 32'h0000A5C3);
    device = ID; command = 6'd1;
    tick();
    check("cmd1 valid", 32'(data_valid), 32'h0);
    check("cmd1 hold", data_out, 32'h0000A5C3);
    command = 6'd4;
    tick();
`ifndef BTN_EVENT_EN
    check("cmd4 disabled valid", 32'(data_valid), 32'h0);
`endif

    // Glitchy btn[2] with READ_BTN held every cycle.
    command = 6'd3;
    btn = 5'b00100; tick();
    btn = 5'b00000; tick();
    btn = 5'b00100; tick();
    ticks(5);
    check("glitch not yet", data_out, 32'h0);
    tick();
    check("btn2 debounced", data_out, 32'h00000004);
    btn = '0; command = 6'd0;
    ticks(8);

    // Reset mid-debounce of btn[3].
    btn = 5'b01000;
    ticks(2);
    reset = 1'b1;
    tick();
    check("mid reset data_out", data_out, 32'h0);
    reset = 1'b0; command = 6'd3;
    ticks(6);
    check("post reset window", data_out, 32'h0);
    tick();
    check("btn3 after window", data_out, 32'h00000008);
    btn = '0; command = 6'd0;
    ticks(8);

`ifdef BTN_EVENT_EN
    command = 6'd4; tick(); command = 6'd0; tick();
    btn = 5'b00001; ticks(8);
    btn = 5'b00000; ticks(8);
    command = 6'd4; tick();
    check("evt btn0", data_out, 32'h00000001);
    check("evt valid", 32'(data_valid), 32'h1);
    tick();
    check("evt cleared", data_out, 32'h00000000);
    command = 6'd0;
    btn = 5'b00010; ticks(5);
    command = 6'd4; tick();
    check("evt same-cycle bit1", 32'(data_out[1]), 32'h0);
    tick();
    check("evt kept bit1", data_out, 32'h00000002);
    command = 6'd0; btn = '0; ticks(8);
`endif

    // Random traffic; buttons change rarely so debounce windows actually complete.
    for (int c = 0; c < 600; c++) begin
      logic [5:0] cmds [6];
      cmds[0] = 6'd0; cmds[1] = 6'd1; cmds[2] = 6'd2; cmds[3] = 6'd3; cmds[4] = 6'd4;
      cmds[5] = 6'($urandom);
      reset   = ($urandom_range(0, 99) == 0);
      device  = ($urandom_range(0, 3) != 0) ? ID : 5'($urandom);
      command = cmds[$urandom_range(0, 5)];
      sw      = 16'($urandom);
      if ($urandom_range(0, 7) == 0) btn[$urandom_range(0, 4)] ^= 1'b1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/switch_reader.md
SWITCH_READER -- requirements
Module: switch_reader

Interface
REQ-001 Parameter DEVICE_ID, default 5'b00001, bus device address this block answers to.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a button change; legal range 2..65535.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 device  input  5  bus device select.
REQ-006 command  input  6  bus command.
REQ-007 sw  input  16  physical slide switches, asynchronous to clk.
REQ-008 btn  input  5  physical push buttons, asynchronous to clk, active-high.
REQ-009 data_out  output  32  read data register.
REQ-010 data_valid  output  1  one-cycle pulse, data_out updated this cycle.

Function
REQ-011 sw and btn SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Each button SHALL have an independent debounce counter, cleared whenever its synchronized value equals its debounced value.
REQ-013 A button's debounced value SHALL take its synchronized value once the counter reaches DEBOUNCE_CYCLES-1 while they differ; the counter then clears.
REQ-014 Switches SHALL be synchronized only, not debounced.
REQ-015 A command is selected when device == DEVICE_ID; otherwise data_out holds and data_valid = 0.
REQ-016 command 6'b000010 (READ_SW): next cycle data_out = {16'd0, synchronized sw}, data_valid = 1.
REQ-017 command 6'b000011 (READ_BTN): next cycle data_out = {27'd0, debounced btn}, data_valid = 1.
REQ-018 Any other command, including 6'b000001, with device == DEVICE_ID: data_out holds, data_valid = 0.
REQ-019 Read latency SHALL be exactly one cycle; a command held N cycles yields N consecutive reads, each sampling the current value.
REQ-020 data_out SHALL hold its last value between reads.

Reset
REQ-021 On reset: data_out = 32'd0, data_valid = 0, synchronizer flops = 0, debounced btn = 0, debounce counters = 0, event register = 0.
REQ-022 Reset asserted mid-debounce SHALL abandon the pending change; after release the change requires a full DEBOUNCE_CYCLES window.
REQ-023 A command present in the same cycle as reset SHALL be ignored.

Configuration
REQ-024 Macro BTN_EVENT_EN, when defined, SHALL add a 5-bit sticky event register; bit i sets on a 0->1 transition of debounced btn[i].
REQ-025 With BTN_EVENT_EN: command 6'b000100 (READ_CLR_EVT) SHALL return {27'd0, events} next cycle with data_valid = 1, and SHALL clear the event register in the same cycle.
REQ-026 With BTN_EVENT_EN: a new rising edge in the same cycle as READ_CLR_EVT SHALL leave that bit set after the clear; the returned data excludes it.
REQ-027 Without BTN_EVENT_EN: no event register exists, and 6'b000100 behaves per REQ-018.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 sw = 16'hA5C3, wait 3 cycles, device = 5'b00001, command = 6'b000010 -> next cycle data_out = 32'h0000A5C3, data_valid = 1 for exactly one cycle.
REQ-029 btn[2] toggles 1/0/1, then held 1 -> READ_BTN returns 32'h00000004 only after 4 stable synchronized cycles; the glitch leaves the debounced value 0.
REQ-030 device = 5'b00010, command = 6'b000010 -> data_out unchanged, data_valid = 0.
REQ-031 BTN_EVENT_EN: press and release btn[0] -> READ_CLR_EVT returns 32'h00000001; second READ_CLR_EVT returns 32'h00000000.
REQ-032 BTN_EVENT_EN: debounced btn[1] rises in the same cycle as READ_CLR_EVT -> returned data bit 1 = 0; next READ_CLR_EVT returns 32'h00000002.
REQ-033 Reset pulsed after btn[3] has been high for 2 cycles -> debounced btn = 0, data_out = 0; READ_BTN reports 32'h00000008 only after the full debounce window elapses post-reset.
